jtag_ir_dr: RTL and testbench
=============================

JTAG_IR_DR -- requirements
Module: jtag_ir_dr

Interface
- REQ-001 SHALL have parameter IDCODE_VAL, default 32'h1234_5679, the 32-bit device identification word; bit 0 SHALL be 1.
- REQ-002 SHALL have port clk, input, 1, the TCK-domain clock; all state updates occur on the rising edge.
- REQ-003 SHALL have port trst, input, 1, the reset: synchronous, active-low.
- REQ-004 SHALL have port tdi, input, 1, serial test data in.
- REQ-005 SHALL have ports captureIR, shiftIR, updateIR, captureDR, shiftDR and updateDR, each input, 1, the TAP phase strobes, sampled at the rising clk edge.
- REQ-006 SHALL have port enable, input, 1, the TAP shift-state output enable.
- REQ-007 SHALL have port tdo, output, 1, serial test data out.
- REQ-008 SHALL have port tdo_oe, output, 1, the tdo output enable.
- REQ-009 SHALL have port ir_out, output, 4, the active instruction.
- REQ-010 SHALL have port user_in, input, 16, the value captured into the user DR.
- REQ-011 SHALL have port user_out, output, 16, the updated user DR value.
- REQ-012 SHALL have port user_update, output, 1, a one-cycle pulse on user DR update.
- REQ-013 SHALL have port shift_cnt, output, 6, the bits shifted in the current shift session.

Function
- REQ-014 Instructions SHALL decode as: 4'b0001 IDCODE, 4'b1000 USER, 4'b1111 BYPASS; every other code SHALL select BYPASS.
- REQ-015 captureIR SHALL load ir_shift with 4'b0101 and clear shift_cnt.
- REQ-016 shiftIR SHALL perform ir_shift <= {tdi, ir_shift[3:1]} and increment shift_cnt.
- REQ-017 updateIR SHALL load ir_out from ir_shift; ir_shift SHALL be unchanged.
- REQ-018 captureDR SHALL load the register selected by ir_out and clear shift_cnt: IDCODE loads IDCODE_VAL; USER loads user_in; BYPASS loads 1'b0.
- REQ-019 shiftDR SHALL right-shift the selected DR with tdi entering at the MSB (bypass is 1 bit) and increment shift_cnt.
- REQ-020 updateDR with USER selected SHALL copy the user shift register to user_out and assert user_update for exactly one cycle.
- REQ-021 updateDR under IDCODE or BYPASS SHALL have no effect.
- REQ-022 shift_cnt SHALL saturate at 63 and SHALL NOT wrap.
- REQ-023 tdo SHALL be combinational: ir_shift[0] when shiftIR=1; otherwise bit 0 of the DR selected by ir_out.
- REQ-024 tdo_oe SHALL equal enable.
- REQ-025 Strobes SHALL be mutually exclusive by contract; if several are high, only the highest-priority strobe SHALL act, in the order captureIR > shiftIR > updateIR > captureDR > shiftDR > updateDR.
- REQ-026 A change of ir_out SHALL select the new DR from the next cycle; DR shift contents SHALL be retained across instruction changes.
- REQ-027 Latency SHALL be one clk from strobe to register change; user_update SHALL assert in the cycle after updateDR is sampled.

Reset
- REQ-028 With trst=0 at a rising edge, ir_out SHALL become 4'b0001 (IDCODE).
- REQ-029 With trst=0 at a rising edge, ir_shift, the IDCODE, user and bypass shift registers, user_out and shift_cnt SHALL become 0, and user_update SHALL become 0.
- REQ-030 Reset SHALL win over every strobe in the same cycle.
- REQ-031 Reset during a shift SHALL abort it with no update of ir_out or user_out.

Configuration
- REQ-032 Macro JTAG_USERDR_EN defined: the USER instruction, 16-bit user shift register, user_out and user_update SHALL be implemented as specified.
- REQ-033 Macro JTAG_USERDR_EN undefined: 4'b1000 SHALL decode as BYPASS, user_out SHALL be tied to 0, user_update SHALL be tied to 0, and user_in SHALL be ignored.

Verification
- REQ-034 Reset, then captureDR followed by 32 shiftDR cycles -> tdo emits 32'h1234_5679 LSB-first; shift_cnt=32.
- REQ-035 captureIR, 4 shiftIR with tdi 0,0,0,1, then updateIR -> tdo first two bits 1,0; ir_out=4'b1000.
- REQ-036 USER selected, user_in=16'hA5C3, captureDR, 16 shifts of 16'h0F0F, updateDR -> tdo streams 16'hA5C3 LSB-first; user_out=16'h0F0F; user_update high one cycle.
- REQ-037 IR loaded with 4'b0110 (undefined code), captureDR, shift tdi pattern 1,0,1 -> tdo 0,1,0 (one-cycle bypass delay).
- REQ-038 trst=0 mid-USER shift after 7 bits -> ir_out=4'b0001, user_out unchanged at 0, shift_cnt=0, no user_update.
- REQ-039 70 consecutive shiftDR cycles -> shift_cnt holds at 63.

Source files
------------

// File: rtl/jtag_ir_dr.sv
// JTAG instruction register plus IDCODE / USER / BYPASS data registers, clocked in the TCK domain.
// Define JTAG_USERDR_EN to build the 16-bit USER data register; without it, code 4'b1000 acts as BYPASS.
module jtag_ir_dr #(
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679
) (
    input  logic        clk,
    input  logic        trst,
    input  logic        tdi,
    input  logic        captureIR,
    input  logic        shiftIR,
    input  logic        updateIR,
    input  logic        captureDR,
    input  logic        shiftDR,
    input  logic        updateDR,
    input  logic        enable,
    output logic        tdo,
    output logic        tdo_oe,
    output logic [3:0]  ir_out,
    input  logic [15:0] user_in,
    output logic [15:0] user_out,
    output logic        user_update,
    output logic [5:0]  shift_cnt
);

    localparam logic [3:0] IR_IDCODE  = 4'b0001;
    localparam logic [3:0] IR_CAPTURE = 4'b0101;
    localparam logic [5:0] CNT_MAX    = 6'd63;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_CIR  = 3'd1;
    localparam logic [2:0] OP_SIR  = 3'd2;
    localparam logic [2:0] OP_UIR  = 3'd3;
    localparam logic [2:0] OP_CDR  = 3'd4;
    localparam logic [2:0] OP_SDR  = 3'd5;
    localparam logic [2:0] OP_UDR  = 3'd6;

    logic [2:0]  op;
    logic [3:0]  ir_q, ir_d;
    logic [3:0]  ir_shift_q, ir_shift_d;
    logic [31:0] id_sr_q, id_sr_d;
    logic        byp_q, byp_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  cnt_inc;
    logic        sel_id;
    logic        sel_user;
    logic        user_tdo;

    // Only one strobe acts per cycle even if the TAP misbehaves.
    always_comb begin
        op = OP_NONE;
        if (captureIR)      op = OP_CIR;
        else if (shiftIR)   op = OP_SIR;
        else if (updateIR)  op = OP_UIR;
        else if (captureDR) op = OP_CDR;
        else if (shiftDR)   op = OP_SDR;
        else if (updateDR)  op = OP_UDR;
    end

    assign sel_id  = (ir_q == IR_IDCODE);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;

    always_comb begin
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        id_sr_d    = id_sr_q;
        byp_d      = byp_q;
        cnt_d      = cnt_q;
        case (op)
            OP_CIR: begin
                ir_shift_d = IR_CAPTURE;
                cnt_d      = 6'd0;
            end
            OP_SIR: begin
                ir_shift_d = {tdi, ir_shift_q[3:1]};
                cnt_d      = cnt_inc;
            end
            OP_UIR: ir_d = ir_shift_q;
            OP_CDR: begin
                cnt_d = 6'd0;
                if (sel_id)         id_sr_d = IDCODE_VAL;
                else if (!sel_user) byp_d   = 1'b0;
            end
            OP_SDR: begin
                cnt_d = cnt_inc;
                if (sel_id)         id_sr_d = {tdi, id_sr_q[31:1]};
                else if (!sel_user) byp_d   = tdi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!trst) begin
            ir_q       <= IR_IDCODE;
            ir_shift_q <= 4'd0;
            id_sr_q    <= 32'd0;
            byp_q      <= 1'b0;
            cnt_q      <= 6'd0;
        end else begin
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            id_sr_q    <= id_sr_d;
            byp_q      <= byp_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef JTAG_USERDR_EN
    localparam logic [3:0] IR_USER = 4'b1000;

    logic [15:0] us_q, us_d;
    logic [15:0] uo_q, uo_d;
    logic        upd_q, upd_d;

    assign sel_user = (ir_q == IR_USER);

    always_comb begin
        us_d  = us_q;
        uo_d  = uo_q;
        upd_d = 1'b0;
        if (sel_user) begin
            case (op)
                OP_CDR: us_d = user_in;
                OP_SDR: us_d = {tdi, us_q[15:1]};
                OP_UDR: begin
                    uo_d  = us_q;
                    upd_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!trst) begin
            us_q  <= 16'd0;
            uo_q  <= 16'd0;
            upd_q <= 1'b0;
        end else begin
            us_q  <= us_d;
            uo_q  <= uo_d;
            upd_q <= upd_d;
        end
    end

    assign user_tdo    = us_q[0];
    assign user_out    = uo_q;
    assign user_update = upd_q;
`else
    logic unused_user_in;

    assign unused_user_in = ^user_in;
    assign sel_user       = 1'b0;
    assign user_tdo       = 1'b0;
    assign user_out       = 16'd0;
    assign user_update    = 1'b0;
`endif

    // The IR path owns tdo only while shiftIR is asserted; otherwise the selected DR drives it.
    always_comb begin
        if (shiftIR)       tdo = ir_shift_q[0];
        else if (sel_id)   tdo = id_sr_q[0];
        else if (sel_user) tdo = user_tdo;
        else               tdo = byp_q;
    end

    assign tdo_oe    = enable;
    assign ir_out    = ir_q;
    assign shift_cnt = cnt_q;

endmodule

// File: tb/tb_jtag_ir_dr.sv
// Bench for jtag_ir_dr: directed vector table, hand sequences and randomized traffic vs. a reference model.
module tb_jtag_ir_dr;

    localparam logic [31:0] IDV = 32'h1234_5679;
`ifdef JTAG_USERDR_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        trst, tdi, enable;
    logic        captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR;
    logic        tdo, tdo_oe, user_update;
    logic [3:0]  ir_out;
    logic [15:0] user_in, user_out;
    logic [5:0]  shift_cnt;

    jtag_ir_dr #(.IDCODE_VAL(IDV)) dut (
        .clk(clk), .trst(trst), .tdi(tdi),
        .captureIR(captureIR), .shiftIR(shiftIR), .updateIR(updateIR),
        .captureDR(captureDR), .shiftDR(shiftDR), .updateDR(updateDR),
        .enable(enable), .tdo(tdo), .tdo_oe(tdo_oe), .ir_out(ir_out),
        .user_in(user_in), .user_out(user_out), .user_update(user_update),
        .shift_cnt(shift_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit tdo_chk = 1'b0;

    // Reference model: registers held as plain values, shifts done arithmetically.
    logic [3:0]  m_ir, m_irs;
    logic [31:0] m_id;
    logic [15:0] m_us, m_uo;
    logic        m_byp, m_upd;
    int          m_cnt;

    function automatic int kind_of(input logic [3:0] ir);
        if (ir == 4'd1) return 0;
        if (USER_EN && ir == 4'd8) return 1;
        return 2;
    endfunction

    function automatic logic model_tdo(input logic sir);
        if (sir) return m_irs[0];
        case (kind_of(m_ir))
            0:       return m_id[0];
            1:       return m_us[0];
            default: return m_byp;
        endcase
    endfunction

    task automatic model_clk(input logic t, input logic [5:0] s, input logic d);
        int pick;
        if (!t) begin
            m_ir = 4'd1; m_irs = 4'd0; m_id = 32'd0; m_us = 16'd0;
            m_byp = 1'b0; m_uo = 16'd0; m_cnt = 0; m_upd = 1'b0;
            return;
        end
        m_upd = 1'b0;
        pick = -1;
        for (int b = 5; b >= 0; b--) begin
            if (s[b]) begin
                pick = b;
                break;
            end
        end
        case (pick)
            5: begin m_irs = 4'd5; m_cnt = 0; end
            4: begin
                m_irs = (m_irs >> 1) + (d ? 4'd8 : 4'd0);
                if (m_cnt < 63) m_cnt = m_cnt + 1;
            end
            3: m_ir = m_irs;
            2: begin
                m_cnt = 0;
                case (kind_of(m_ir))
                    0:       m_id = IDV;
                    1:       m_us = user_in;
                    default: m_byp = 1'b0;
                endcase
            end
            1: begin
                if (m_cnt < 63) m_cnt = m_cnt + 1;
                case (kind_of(m_ir))
                    0:       m_id = (m_id >> 1) + (d ? 32'h8000_0000 : 32'd0);
                    1:       m_us = (m_us >> 1) + (d ? 16'h8000 : 16'd0);
                    default: m_byp = d;
                endcase
            end
            0: if (kind_of(m_ir) == 1) begin m_uo = m_us; m_upd = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One TCK cycle: drive, check tdo before the edge, clock, check registered outputs.
    task automatic step(input logic t, input logic [5:0] s, input logic d, input logic e, output logic p);
        trst = t;
        {captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR} = s;
        tdi = d;
        enable = e;
        #1;
        p = tdo;
        if (tdo_chk) chk("tdo", 32'(tdo), 32'(model_tdo(s[4])));
        chk("tdo_oe", 32'(tdo_oe), 32'(e));
        @(posedge clk);
        model_clk(t, s, d);
        #1;
        chk("ir_out", 32'(ir_out), 32'(m_ir));
        chk("user_out", 32'(user_out), 32'(m_uo));
        chk("user_update", 32'(user_update), 32'(m_upd));
        chk("shift_cnt", 32'(shift_cnt), 32'(m_cnt));
        tdo_chk = 1'b1;
    endtask

    task automatic load_ir(input logic [3:0] code);
        logic p;
        step(1'b1, 6'b100000, 1'b0, 1'b1, p);
        for (int i = 0; i < 4; i++) step(1'b1, 6'b010000, code[i], 1'b1, p);
        step(1'b1, 6'b001000, 1'b0, 1'b1, p);
    endtask

    typedef struct {
        logic       trst;
        logic [5:0] s;
        logic       tdi;
        logic       en;
        logic       exp_tdo;
        logic [3:0] exp_ir;
        logic [5:0] exp_cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic        p;
        logic [15:0] uv, pat;
        logic [5:0]  s;
        int          r;

        trst = 1'b0; tdi = 1'b0; enable = 1'b0; user_in = 16'd0;
        {captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR} = 6'd0;

        // IR scan to 4'b1000, then to undefined 4'b0110 and a short bypass shift
        tbl[0]  = '{1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 4'b0001, 6'd0};
        tbl[1]  = '{1'b1, 6'b010000, 1'b0, 1'b0, 1'b1, 4'b0001, 6'd1};
        tbl[2]  = '{1'b1, 6'b010000, 1'b0, 1'b1, 1'b0, 4'b0001, 6'd2};
        tbl[3]  = '{1'b1, 6'b010000, 1'b0, 1'b1, 1'b1, 4'b0001, 6'd3};
        tbl[4]  = '{1'b1, 6'b010000, 1'b1, 1'b0, 1'b0, 4'b0001, 6'd4};
        tbl[5]  = '{1'b1, 6'b001000, 1'b0, 1'b0, 1'b0, 4'b1000, 6'd4};
        tbl[6]  = '{1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 4'b1000, 6'd0};
        tbl[7]  = '{1'b1, 6'b010000, 1'b0, 1'b1, 1'b1, 4'b1000, 6'd1};
        tbl[8]  = '{1'b1, 6'b010000, 1'b1, 1'b1, 1'b0, 4'b1000, 6'd2};
        tbl[9]  = '{1'b1, 6'b010000, 1'b1, 1'b0, 1'b1, 4'b1000, 6'd3};
        tbl[10] = '{1'b1, 6'b010000, 1'b0, 1'b1, 1'b0, 4'b1000, 6'd4};
        tbl[11] = '{1'b1, 6'b001000, 1'b0, 1'b1, 1'b0, 4'b0110, 6'd4};
        tbl[12] = '{1'b1, 6'b000100, 1'b0, 1'b1, 1'b0, 4'b0110, 6'd0};
        tbl[13] = '{1'b1, 6'b000010, 1'b1, 1'b1, 1'b0, 4'b0110, 6'd1};
        tbl[14] = '{1'b1, 6'b000010, 1'b0, 1'b1, 1'b1, 4'b0110, 6'd2};
        tbl[15] = '{1'b1, 6'b000010, 1'b1, 1'b1, 1'b0, 4'b0110, 6'd3};
        tbl[16] = '{1'b1, 6'b000000, 1'b0, 1'b0, 1'b1, 4'b0110, 6'd3};

        @(negedge clk);
        step(1'b0, 6'b000000, 1'b0, 1'b0, p);
        chk("rst_ir", 32'(ir_out), 32'h1);
        chk("rst_cnt", 32'(shift_cnt), 32'h0);
        chk("rst_user_out", 32'(user_out), 32'h0);
        chk("rst_user_update", 32'(user_update), 32'h0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].trst, tbl[i].s, tbl[i].tdi, tbl[i].en, p);
            chk($sformatf("tbl%0d_tdo", i), 32'(p), 32'(tbl[i].exp_tdo));
            chk($sformatf("tbl%0d_ir", i), 32'(ir_out), 32'(tbl[i].exp_ir));
            chk($sformatf("tbl%0d_cnt", i), 32'(shift_cnt), 32'(tbl[i].exp_cnt));
        end

        // IDCODE readout after reset
        step(1'b0, 6'b111111, 1'b1, 1'b0, p);
        chk("rst_wins_ir", 32'(ir_out), 32'h1);
        step(1'b1, 6'b000100, 1'b0, 1'b1, p);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 6'b000010, 1'($urandom_range(0, 1)), 1'b1, p);
            chk($sformatf("idcode_bit%0d", i), 32'(p), 32'(IDV[i]));
        end
        chk("idcode_cnt", 32'(shift_cnt), 32'd32);

        // USER capture / shift / update
        step(1'b0, 6'b000000, 1'b0, 1'b0, p);
        load_ir(4'b1000);
        uv = 16'hA5C3;
        pat = 16'h0F0F;
        user_in = uv;
        step(1'b1, 6'b000100, 1'b0, 1'b1, p);
        user_in = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 6'b000010, pat[i], 1'b1, p);
            if (USER_EN) chk($sformatf("user_bit%0d", i), 32'(p), 32'(uv[i]));
        end
        chk("user_cnt", 32'(shift_cnt), 32'd16);
        step(1'b1, 6'b000001, 1'b0, 1'b1, p);
        chk("user_out_upd", 32'(user_out), USER_EN ? 32'h0F0F : 32'h0);
        chk("user_update_hi", 32'(user_update), USER_EN ? 32'h1 : 32'h0);
        step(1'b1, 6'b000000, 1'b0, 1'b1, p);
        chk("user_update_lo", 32'(user_update), 32'h0);

        // Reset in the middle of a USER shift
        step(1'b0, 6'b000000, 1'b0, 1'b0, p);
        load_ir(4'b1000);
        step(1'b1, 6'b000100, 1'b0, 1'b1, p);
        for (int i = 0; i < 7; i++) step(1'b1, 6'b000010, 1'b1, 1'b1, p);
        chk("midshift_cnt", 32'(shift_cnt), 32'd7);
        step(1'b0, 6'b000011, 1'b1, 1'b1, p);
        chk("abort_ir", 32'(ir_out), 32'h1);
        chk("abort_user_out", 32'(user_out), 32'h0);
        chk("abort_cnt", 32'(shift_cnt), 32'h0);
        chk("abort_upd", 32'(user_update), 32'h0);
        step(1'b1, 6'b000000, 1'b0, 1'b1, p);
        chk("abort_upd_next", 32'(user_update), 32'h0);

        // Counter saturation
        step(1'b1, 6'b000100, 1'b0, 1'b1, p);
        for (int i = 0; i < 70; i++) step(1'b1, 6'b000010, 1'($urandom_range(0, 1)), 1'b1, p);
        chk("cnt_sat", 32'(shift_cnt), 32'd63);

        // Randomized traffic, including overlapping strobes and stray resets
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                r = $urandom_range(0, 3);
                case (r)
                    0:       load_ir(4'b0001);
                    1:       load_ir(4'b1000);
                    2:       load_ir(4'b1111);
                    default: load_ir(4'($urandom_range(0, 15)));
                endcase
            end
            r = $urandom_range(0, 19);
            if (r < 12)      s = 6'd1 << (r % 6);
            else if (r < 16) s = 6'd0;
            else             s = 6'($urandom_range(0, 63));
            user_in = 16'($urandom);
            step(($urandom_range(0, 99) != 0), s, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
